// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the data-memory responder:
//   MEM_DATA_W / MEM_ADDR_W : default datapath word and word-address widths
//   mem_rsp_state_t         : responder FSM states (IDLE, WAIT, RESP)
//   mem_parity()            : even parity (XOR-reduce) of a data word
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam int MEM_DATA_W = 16;
    localparam int MEM_ADDR_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_rsp_state_t;

    function automatic logic mem_parity(input logic [MEM_DATA_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// -----------------------------------------------------------------------------
// mem_responder_if
// Load/store request/response bundle between the core (master) and the
// data-memory responder (slave).
//   req_valid / req_ready   : request handshake
//   req_we, req_addr,
//   req_wdata               : request payload (1 = write)
//   rsp_valid / rsp_ready   : response handshake
//   rsp_rdata, rsp_is_write : response payload (rdata is 0 for writes)
//   rsp_parity              : even parity of rsp_rdata, only when
//                             MEM_RSP_PARITY_EN is defined
// -----------------------------------------------------------------------------
interface mem_responder_if
    import mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_is_write;
`ifdef MEM_RSP_PARITY_EN
    logic              rsp_parity;
`endif

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
`ifdef MEM_RSP_PARITY_EN
        input  rsp_parity,
`endif
        input  req_ready, rsp_valid, rsp_rdata, rsp_is_write
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
`ifdef MEM_RSP_PARITY_EN
        output rsp_parity,
`endif
        output req_ready, rsp_valid, rsp_rdata, rsp_is_write
    );

endinterface

// File: rtl/mem_array.sv
// -----------------------------------------------------------------------------
// mem_array
// Single-port synchronous RAM, 2**ADDR_W words of DATA_W bits.
// Registered read (read-before-write on a same-address write), no reset.
//   clk   : clock
//   we    : write enable
//   addr  : word address (read and write)
//   wdata : write data
//   rdata : registered read data
// -----------------------------------------------------------------------------
module mem_array
    import mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata <= mem_q[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Target end of the core's load/store interface. Accepts one request at a
// time, reads or writes the internal word array, and presents the response
// LATENCY cycles after the accept edge, holding it until rsp_ready.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : mem_responder_if.slave (request and response channels)
// Parameters: ADDR_W (word address width), DATA_W (16), LATENCY (1..15).
// Optional: define MEM_RSP_PARITY_EN to drive bus.rsp_parity, the even
// parity of rsp_rdata.
// -----------------------------------------------------------------------------
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int DATA_W  = MEM_DATA_W,
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("mem_responder: LATENCY=%0d outside 1..15", LATENCY);
    end

    // WAIT counts down to zero; entering it with LATENCY-2 puts RESP
    // exactly LATENCY edges after the accept edge.
    localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    mem_rsp_state_t    state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic              rd_q, rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic              accept;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] rsp_rdata;

    assign accept = (state_q == IDLE) && bus.req_valid;
    assign ram_we = accept && bus.req_we;

    // Outside IDLE the RAM keeps re-reading the latched address. No write
    // can occur then, so its read register acts as the stable hold register
    // for the whole response stall.
    assign ram_addr = (state_q == IDLE) ? bus.req_addr : addr_q;

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (bus.req_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            rd_q    <= rd_d;
        end
        addr_q <= addr_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d   = bus.req_we;
                    rd_d   = !bus.req_we;
                    addr_d = bus.req_addr;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                    we_d    = 1'b0;
                    rd_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Write responses and the post-reset state present zero data.
    assign rsp_rdata        = rd_q ? ram_rdata : '0;
    assign bus.rsp_rdata    = rsp_rdata;
    assign bus.rsp_is_write = we_q;
    assign bus.req_ready    = (state_q == IDLE);
    assign bus.rsp_valid    = (state_q == RESP);

`ifdef MEM_RSP_PARITY_EN
    assign bus.rsp_parity = mem_parity(rsp_rdata);
`endif

endmodule
